ventana_3x3_pixeles: RTL

// - Downstream consumer of buffer_pixeles_mem: pops 8-bit raster-order pixels, builds sliding 3x3 neighbourhoods, hands them to the filter core.
// - Two on-chip line memories hold rows r-1 and r-2; a 3x3 register window shifts one column per accepted pixel.
// - Window output is registered, with a valid/ready handshake toward the filter stage.
// - No border padding: each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.

---
 rtl/ventana_3x3_pixeles_if.sv | 29 ++
 rtl/ventana_3x3_pixeles.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ventana_3x3_pixeles_if.sv
// Pixel-in / window-out stream bundle between the pixel buffer, window builder and filter core.
interface ventana_3x3_pixeles_if;
  logic [7:0]  pixel;
  logic        data_available;
  logic        read_pixel;
  logic [71:0] window;
  logic        window_valid;
  logic        window_ready;

  // Window builder side: pops pixels, produces windows
  modport master (
    input  pixel,
    input  data_available,
    input  window_ready,
    output read_pixel,
    output window,
    output window_valid
  );

  // Environment side: supplies pixels, consumes windows
  modport slave (
    output pixel,
    output data_available,
    output window_ready,
    input  read_pixel,
    input  window,
    input  window_valid
  );
endinterface

// File: rtl/ventana_3x3_pixeles.sv
// Sliding 3x3 neighbourhood builder over a raster pixel stream.
// Two line memories hold rows r-1/r-2; a register window shifts one column per accepted pixel.
module ventana_3x3_pixeles #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  ventana_3x3_pixeles_if.master   bus,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam int unsigned PW = 8;
  localparam int unsigned WW = 9 * PW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [WW-1:0] win_q;
  logic [WW-1:0] window_nxt;
  logic          win_valid_q;
  logic          accept;
  logic          col_last;
  logic          last_pix;
  logic          win_formed;
  logic [PW-1:0] line_r1 [IMG_WIDTH];
  logic [PW-1:0] line_r2 [IMG_WIDTH];
  logic [PW-1:0] line_r1_rd;
  logic [PW-1:0] line_r2_rd;

  assign bus.window       = win_q;
  assign bus.window_valid = win_valid_q;

  // Pop only while running and the output slot is free or being drained this edge
  assign accept         = (state == S_RUN) & bus.data_available & (~win_valid_q | bus.window_ready);
  assign bus.read_pixel = accept;

  assign col_last   = (col == CW'(IMG_WIDTH - 1));
  assign last_pix   = col_last && (row == RW'(IMG_HEIGHT - 1));
  assign win_formed = (row >= RW'(2)) && (col >= CW'(2));
  assign line_r1_rd = line_r1[col];
  assign line_r2_rd = line_r2[col];

  // New right column {r-2, r-1, pixel}; older columns shift toward k=3r
  always_comb begin
    window_nxt = win_q;
    window_nxt = {bus.pixel,  win_q[71:56],
                  line_r1_rd, win_q[47:32],
                  line_r2_rd, win_q[23:8]};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && last_pix) state_nxt = S_DRAIN;
      S_DRAIN: if (!win_valid_q || bus.window_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status flags registered from the next state so they line up with the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      busy       <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      frame_done <= (state_nxt == S_DONE);
    end
  end

  // Raster counters, window register and output-valid tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        col <= '0;
        row <= '0;
      end
      if (accept) begin
        win_q       <= window_nxt;
        win_valid_q <= win_formed;
        if (col_last) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else if (win_valid_q && bus.window_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  // Line memories: contents are don't-care after reset, so no reset branch
  always_ff @(posedge clk) begin
    if (accept) begin
      line_r2[col] <= line_r1_rd;
      line_r1[col] <= bus.pixel;
    end
  end

endmodule
